pc_unit_mt: RTL and testbench



---
 rtl/pc_unit_mt.sv | 133 +++++++++++++
 tb/tb_pc_unit_mt.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pc_unit_mt.sv
// pc_unit_mt: multi-hart PC unit with round-robin fetch and per-hart redirect/trap capture
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   stall          in   freezes PC advance and the round-robin pointer
//   fetch_ready    in   fetch stage accepts the offered PC
//   fetch_valid    out  offered PC is valid
//   fetch_hart     out  hart of the offered PC
//   fetch_pc       out  offered PC
//   redirect_valid in   branch/jump redirect request
//   redirect_hart  in   redirect target hart
//   redirect_pc    in   redirect target address
//   trap_valid     in   trap request
//   trap_hart      in   trapping hart
//   pend_any       out  at least one hart holds a captured redirect or trap
//   misalign_err   out  only with PC_MISALIGN_TRAP_EN: pulses one cycle after a misaligned redirect
//
// Optional feature macro: PC_MISALIGN_TRAP_EN turns misaligned redirects into traps.
module pc_unit_mt #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned NUM_HARTS = 2,
    parameter int unsigned INSTR_BYTES = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VEC = 'h100,
    localparam int unsigned HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [HART_W-1:0]     fetch_hart,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  redirect_valid,
    input  logic [HART_W-1:0]     redirect_hart,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  trap_valid,
    input  logic [HART_W-1:0]     trap_hart,
    output logic                  pend_any
`ifdef PC_MISALIGN_TRAP_EN
   ,output logic                  misalign_err
`endif
);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [HART_W-1:0] LAST = HART_W'(NUM_HARTS - 1);

    logic [ADDR_WIDTH-1:0] pc_q [NUM_HARTS];
    logic [ADDR_WIDTH-1:0] pc_d [NUM_HARTS];
    logic [ADDR_WIDTH-1:0] pend_pc_q [NUM_HARTS];
    logic [ADDR_WIDTH-1:0] pend_pc_d [NUM_HARTS];
    logic [ADDR_WIDTH-1:0] tgt [NUM_HARTS];
    logic [NUM_HARTS-1:0]  pend_q, pend_d, hit, trap_h;
    logic [HART_W-1:0]     rr_q, rr_d;
    logic                  run_q, run_d, accept;
    logic [ADDR_WIDTH-1:0] redir_tgt;

    assign redir_tgt = redirect_pc & ~ALIGN_MASK;

`ifdef PC_MISALIGN_TRAP_EN
    logic bad_align, misalign_err_q, misalign_err_d;
    // Requests to nonexistent harts are ignored, so they raise no error either.
    assign bad_align = redirect_valid & (|(redirect_pc & ALIGN_MASK));
    assign misalign_err_d = bad_align & (32'(redirect_hart) < NUM_HARTS);
    assign misalign_err = misalign_err_q;
`endif

    // Per-hart request decode; a trap outranks a redirect to the same hart.
    always_comb begin
        hit = '0;
        trap_h = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            trap_h[h] = trap_valid && (trap_hart == HART_W'(h));
`ifdef PC_MISALIGN_TRAP_EN
            trap_h[h] = trap_h[h] | (bad_align && (redirect_hart == HART_W'(h)));
`endif
            hit[h] = trap_h[h] | (redirect_valid && (redirect_hart == HART_W'(h)));
            tgt[h] = trap_h[h] ? TRAP_VEC : redir_tgt;
        end
    end

    assign fetch_hart  = rr_q;
    assign fetch_pc    = pc_q[rr_q];
    // A hart with a request in flight is held back so it is never offered a stale PC.
    assign fetch_valid = run_q & ~stall & ~pend_q[rr_q] & ~hit[rr_q];
    assign accept      = fetch_valid & fetch_ready;
    assign pend_any    = |pend_q;

    always_comb begin
        pc_d = pc_q;
        pend_d = pend_q;
        pend_pc_d = pend_pc_q;
        run_d = 1'b1;
        rr_d = accept ? ((rr_q == LAST) ? '0 : rr_q + HART_W'(1)) : rr_q;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (hit[h]) begin
                pend_d[h] = stall;
                pend_pc_d[h] = stall ? tgt[h] : pend_pc_q[h];
                pc_d[h] = stall ? pc_q[h] : tgt[h];
            end else if (pend_q[h] && !stall) begin
                pc_d[h] = pend_pc_q[h];
                pend_d[h] = 1'b0;
            end else if (accept && (rr_q == HART_W'(h))) begin
                pc_d[h] = pc_q[h] + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                pc_q[h] <= RESET_ADDR;
                pend_pc_q[h] <= '0;
            end
            pend_q <= '0;
            rr_q <= '0;
            run_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err_q <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            pend_pc_q <= pend_pc_d;
            pend_q <= pend_d;
            rr_q <= rr_d;
            run_q <= run_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_err_q <= misalign_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_pc_unit_mt.sv
// tb_pc_unit_mt: table-driven scoreboard bench for pc_unit_mt (2 harts, 64-bit PCs)
module tb_pc_unit_mt;
    typedef struct {
        logic        st, rdy, rv, rh, tv, th;
        logic [63:0] rpc;
        logic        ev, eh, ep, em;
        logic [63:0] epc;
    } vec_t;

`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [63:0] MB = 64'h100;
`else
    localparam logic [63:0] MB = 64'h3000;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        stall = 1'b0, fetch_ready = 1'b0, fetch_valid;
    logic        fetch_hart, redirect_valid = 1'b0, redirect_hart = 1'b0;
    logic        trap_valid = 1'b0, trap_hart = 1'b0, pend_any;
    logic [63:0] fetch_pc, redirect_pc = '0;
    logic        mis;
`ifndef PC_MISALIGN_TRAP_EN
    assign mis = 1'b0;
`endif

    int   checks = 0, failures = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pc_unit_mt dut (
        .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_hart(fetch_hart), .fetch_pc(fetch_pc),
        .redirect_valid(redirect_valid), .redirect_hart(redirect_hart), .redirect_pc(redirect_pc),
        .trap_valid(trap_valid), .trap_hart(trap_hart), .pend_any(pend_any)
`ifdef PC_MISALIGN_TRAP_EN
       ,.misalign_err(mis)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, rdy, rv, rh, input logic [63:0] rpc,
                                input logic tv, th, ev, eh, input logic [63:0] epc,
                                input logic ep, em);
        vec_t v;
        v.st = st; v.rdy = rdy; v.rv = rv; v.rh = rh; v.rpc = rpc; v.tv = tv; v.th = th;
        v.ev = ev; v.eh = eh; v.epc = epc; v.ep = ep; v.em = em;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        stall = v.st; fetch_ready = v.rdy;
        redirect_valid = v.rv; redirect_hart = v.rh; redirect_pc = v.rpc;
        trap_valid = v.tv; trap_hart = v.th;
    endtask

    initial begin
        vec_t e;
        int   n;
        // st rdy rv rh rpc | tv th | ev eh epc | ep em
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 0,0,64'h0,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h0,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h0,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h4,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h4,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h8,   0,0));
        tbl.push_back(mk(0,0,0,0,64'h0,   0,0, 1,1,64'h8,   0,0));
        tbl.push_back(mk(0,0,0,0,64'h0,   0,0, 1,1,64'h8,   0,0));
        tbl.push_back(mk(0,0,0,0,64'h0,   0,0, 1,1,64'h8,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h8,   0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'hC,   0,0));
        tbl.push_back(mk(1,1,1,1,64'h2002,0,0, 0,1,64'hC,   0,0));
        tbl.push_back(mk(1,1,0,0,64'h0,   0,0, 0,1,64'hC,   1,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 0,1,64'hC,   1,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h2000,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h10,  0,0));
        tbl.push_back(mk(0,1,1,0,64'h500, 1,0, 1,1,64'h2004,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h100, 0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h2008,0,0));
        tbl.push_back(mk(0,1,1,0,64'hFFFF_FFFF_FFFF_FFFC,0,0, 0,0,64'h104,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'hFFFF_FFFF_FFFF_FFFC,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,64'h200C,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h0,   0,0));
        tbl.push_back(mk(0,1,1,1,64'h3001,0,0, 0,1,64'h2010,0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,MB,      0,1));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h4,   0,0));
        tbl.push_back(mk(1,1,1,0,64'h600, 0,0, 0,1,MB+4,    0,0));
        tbl.push_back(mk(1,1,0,0,64'h0,   1,0, 0,1,MB+4,    1,0));
        tbl.push_back(mk(0,1,1,0,64'h700, 0,0, 1,1,MB+4,    1,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,0,64'h700, 0,0));
        tbl.push_back(mk(0,1,0,0,64'h0,   0,0, 1,1,MB+8,    0,0));

        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset valid", {63'b0, fetch_valid}, 64'h0);
        chk("reset pend_any", {63'b0, pend_any}, 64'h0);
        chk("reset hart", {63'b0, fetch_hart}, 64'h0);
        chk("reset pc", fetch_pc, 64'h0);
        chk("reset misalign", {63'b0, mis}, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk($sformatf("row%0d scoreboard empty", i), 64'h0, 64'h1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d valid", i), {63'b0, fetch_valid}, {63'b0, e.ev});
                chk($sformatf("row%0d hart", i), {63'b0, fetch_hart}, {63'b0, e.eh});
                chk($sformatf("row%0d pc", i), fetch_pc, e.epc);
                chk($sformatf("row%0d pend_any", i), {63'b0, pend_any}, {63'b0, e.ep});
`ifdef PC_MISALIGN_TRAP_EN
                chk($sformatf("row%0d misalign", i), {63'b0, mis}, {63'b0, e.em});
`endif
            end
            @(posedge clk);
            #1;
        end

        // Capture a pending redirect, then assert reset mid-cycle: state must clear at once.
        drive(mk(1,1,1,1,64'h4000,0,0,0,0,0,0,0));
        @(posedge clk);
        #1 drive(mk(1,1,0,0,64'h0,0,0,0,0,0,0,0));
        #1 chk("pend before async reset", {63'b0, pend_any}, 64'h1);
        reset = 1'b0;
        #1;
        chk("async reset valid", {63'b0, fetch_valid}, 64'h0);
        chk("async reset pend_any", {63'b0, pend_any}, 64'h0);
        chk("async reset pc", fetch_pc, 64'h0);
        chk("async reset hart", {63'b0, fetch_hart}, 64'h0);
        stall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        n = 0;
        @(negedge clk);
        while (!fetch_valid && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("cycles to first offer", 64'(n), 64'h1);
        chk("post-reset hart", {63'b0, fetch_hart}, 64'h0);
        chk("post-reset pc", fetch_pc, 64'h0);
        @(negedge clk);
        chk("post-reset hart1 valid", {63'b0, fetch_valid}, 64'h1);
        chk("post-reset hart1 id", {63'b0, fetch_hart}, 64'h1);
        chk("post-reset hart1 pc", fetch_pc, 64'h0);
        chk("post-reset pend_any", {63'b0, pend_any}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
